// File: rtl/fpu_ss_regfile_sb.sv
// fpu_ss_regfile_sb: FPU subsystem register file with a per-register busy scoreboard.
// Issue reads operands and reserves a destination; writeback ports write results and
// release the reservation.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset (clears data and busy bits)
//   raddr_i      NumRead read addresses
//   rdata_o      NumRead read data (combinational, optional write bypass)
//   rbusy_o      busy status of each read address after same-cycle release
//   waddr_i      NumWrite write addresses
//   wdata_i      NumWrite write data
//   we_i         NumWrite write enables (higher index wins on collision)
//   rsv_valid_i  reservation request
//   rsv_addr_i   register to reserve
//   rsv_ready_o  reservation accepted this cycle
//   busy_o       registered busy vector
module fpu_ss_regfile_sb #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 32,
    parameter int unsigned NumRead   = 3,
    parameter int unsigned NumWrite  = 2,
    parameter bit          ZeroReg   = 1'b0,
    parameter bit          Forward   = 1'b1,
    localparam int unsigned AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumRead-1:0][AddrWidth-1:0]   raddr_i,
    output logic [NumRead-1:0][DataWidth-1:0]   rdata_o,
    output logic [NumRead-1:0]                  rbusy_o,
    input  logic [NumWrite-1:0][AddrWidth-1:0]  waddr_i,
    input  logic [NumWrite-1:0][DataWidth-1:0]  wdata_i,
    input  logic [NumWrite-1:0]                 we_i,
    input  logic                                rsv_valid_i,
    input  logic [AddrWidth-1:0]                rsv_addr_i,
    output logic                                rsv_ready_o,
    output logic [NumWords-1:0]                 busy_o
);

    localparam int unsigned NumSlots = 2 ** AddrWidth;

    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] mem_d [NumWords];
    logic [NumWords-1:0]  busy_q, busy_d;
    logic [NumSlots-1:0]  addr_ok;  // address decodes to an implemented register
    logic [NumWords-1:0]  rel;      // some enabled write targets this register now
    logic                 rsv_zero;
    logic                 rsv_accept;

    always_comb begin
        for (int unsigned k = 0; k < NumSlots; k++) begin
            addr_ok[k] = (k < NumWords);
        end
    end

    always_comb begin
        rel = '0;
        for (int unsigned p = 0; p < NumWrite; p++) begin
            if (we_i[p] && addr_ok[waddr_i[p]]) begin
                rel[waddr_i[p]] = 1'b1;
            end
        end
    end

    // Release clears busy, so a register can be re-reserved in the cycle its result lands.
    assign rsv_zero    = ZeroReg && (rsv_addr_i == '0);
    assign rsv_accept  = rsv_valid_i && addr_ok[rsv_addr_i] &&
                         (rsv_zero || !busy_q[rsv_addr_i] || rel[rsv_addr_i]);
    assign rsv_ready_o = rsv_accept;
    assign busy_o      = busy_q;

    always_comb begin
        mem_d = mem_q;
        // Ascending loop so the highest-index port wins a collision.
        for (int unsigned p = 0; p < NumWrite; p++) begin
            if (we_i[p] && addr_ok[waddr_i[p]] && !(ZeroReg && waddr_i[p] == '0)) begin
                mem_d[waddr_i[p]] = wdata_i[p];
            end
        end
        // Set after clear: a new reservation beats a same-cycle release.
        busy_d = busy_q & ~rel;
        if (rsv_accept && !rsv_zero) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < NumRead; r++) begin
            rdata_o[r] = '0;
            rbusy_o[r] = 1'b0;
            if (addr_ok[raddr_i[r]] && !(ZeroReg && raddr_i[r] == '0)) begin
                rdata_o[r] = mem_q[raddr_i[r]];
                if (Forward) begin
                    for (int unsigned p = 0; p < NumWrite; p++) begin
                        if (we_i[p] && waddr_i[p] == raddr_i[r]) begin
                            rdata_o[r] = wdata_i[p];
                        end
                    end
                end
                rbusy_o[r] = busy_q[raddr_i[r]] & ~rel[raddr_i[r]];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < NumWords; k++) begin
                mem_q[k] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: tb/tb_fpu_ss_regfile_sb.sv
// Testbench for fpu_ss_regfile_sb: a table of directed per-cycle vectors against the
// default configuration, plus hand sequences for ZeroReg=1 (with out-of-range words)
// and Forward=0 instances that share the same stimulus.
module tb_fpu_ss_regfile_sb;

    logic             clk;
    logic             rst;
    logic [2:0][4:0]  raddr;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wdata;
    logic [1:0]       we;
    logic             rsv_valid;
    logic [4:0]       rsv_addr;

    logic [2:0][31:0] rdata_a, rdata_z, rdata_n;
    logic [2:0]       rbusy_a, rbusy_z, rbusy_n;
    logic             ready_a, ready_z, ready_n;
    logic [31:0]      busy_a, busy_n;
    logic [23:0]      busy_z;

    int n_tests = 0;
    int n_fail  = 0;

    fpu_ss_regfile_sb #(.NumWords(32), .ZeroReg(1'b0), .Forward(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_a), .busy_o(busy_a)
    );

    fpu_ss_regfile_sb #(.NumWords(24), .ZeroReg(1'b1), .Forward(1'b1)) dut_z (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_z), .rbusy_o(rbusy_z),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_z), .busy_o(busy_z)
    );

    fpu_ss_regfile_sb #(.NumWords(32), .ZeroReg(1'b0), .Forward(1'b0)) dut_n (
        .clk_i(clk), .rst_i(rst), .raddr_i(raddr), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .rsv_valid_i(rsv_valid),
        .rsv_addr_i(rsv_addr), .rsv_ready_o(ready_n), .busy_o(busy_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [4:0]  ra;
        logic        rv;
        logic [4:0]  rsa;
        logic [31:0] e_rdata;  // all three read ports, before the edge
        logic        e_rbusy;
        logic        e_ready;
        logic [31:0] e_busy;   // busy_o after the edge
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; we = '0; waddr = '0; wdata = '0;
        raddr = '0; rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    task automatic reset_cycle();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        //          rst we     wa0 wd0            wa1 wd1            ra  rv rsa
        //          e_rdata        rb rdy e_busy
        vecs[0]  = '{1'b0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 1'b0, 5'd0,
                     32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 1'b1, 5'd5,
                     32'hDEADBEEF, 1'b0, 1'b1, 32'h20};
        vecs[2]  = '{1'b1, 2'b01, 5'd5, 32'h1234, 5'd0, 32'h0, 5'd5, 1'b1, 5'd12,
                     32'h1234, 1'b0, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 1'b1, 5'd5,
                     32'h0, 1'b0, 1'b1, 32'h20};
        vecs[4]  = '{1'b0, 2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 5'd7, 1'b1, 5'd5,
                     32'h22222222, 1'b0, 1'b0, 32'h20};
        vecs[5]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 1'b1, 5'd3,
                     32'h22222222, 1'b0, 1'b1, 32'h28};
        vecs[6]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 1'b1, 5'd3,
                     32'h0, 1'b1, 1'b0, 32'h28};
        vecs[7]  = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd3, 32'hCAFEF00D, 5'd3, 1'b1, 5'd3,
                     32'hCAFEF00D, 1'b0, 1'b1, 32'h28};
        vecs[8]  = '{1'b0, 2'b01, 5'd3, 32'h0BADF00D, 5'd0, 32'h0, 5'd3, 1'b0, 5'd0,
                     32'h0BADF00D, 1'b0, 1'b0, 32'h20};
        vecs[9]  = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 1'b1, 5'd12,
                     32'h0BADF00D, 1'b0, 1'b1, 32'h1020};
        vecs[10] = '{1'b1, 2'b01, 5'd12, 32'h55AA55AA, 5'd0, 32'h0, 5'd12, 1'b0, 5'd0,
                     32'h55AA55AA, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd12, 1'b1, 5'd12,
                     32'h0, 1'b0, 1'b1, 32'h1000};
        vecs[12] = '{1'b0, 2'b10, 5'd0, 32'h0, 5'd5, 32'h77, 5'd5, 1'b0, 5'd0,
                     32'h77, 1'b0, 1'b0, 32'h1000};
        vecs[13] = '{1'b0, 2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 1'b1, 5'd0,
                     32'hFFFFFFFF, 1'b0, 1'b1, 32'h1001};

        reset_cycle();
        #3;
        check("reset rdata", rdata_a[0], 32'h0);
        check("reset busy", busy_a, 32'h0);

        foreach (vecs[i]) begin
            rst       = vecs[i].rst;
            we        = vecs[i].we;
            waddr[0]  = vecs[i].wa0;
            wdata[0]  = vecs[i].wd0;
            waddr[1]  = vecs[i].wa1;
            wdata[1]  = vecs[i].wd1;
            raddr[0]  = vecs[i].ra;
            raddr[1]  = vecs[i].ra;
            raddr[2]  = vecs[i].ra;
            rsv_valid = vecs[i].rv;
            rsv_addr  = vecs[i].rsa;
            #3;
            for (int r = 0; r < 3; r++) begin
                check($sformatf("v%0d rdata%0d", i, r), rdata_a[r], vecs[i].e_rdata);
                check($sformatf("v%0d rbusy%0d", i, r), 32'(rbusy_a[r]), 32'(vecs[i].e_rbusy));
            end
            check($sformatf("v%0d rsv_ready", i), 32'(ready_a), 32'(vecs[i].e_ready));
            @(posedge clk); #1;
            check($sformatf("v%0d busy_o", i), busy_a, vecs[i].e_busy);
        end

        // ZeroReg=1: writes and reservations of r0 have no effect.
        reset_cycle();
        we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFFFFFF;
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        #3;
        check("zr r0 fwd rdata", rdata_z[0], 32'h0);
        check("zr r0 rsv_ready", 32'(ready_z), 32'h1);
        check("nf r0 same-cycle rdata", rdata_n[0], 32'h0);
        check("nf r0 rsv_ready", 32'(ready_n), 32'h1);
        @(posedge clk); #1;
        idle();
        #3;
        check("zr r0 busy_o", 32'(busy_z), 32'h0);
        check("zr r0 rdata", rdata_z[0], 32'h0);
        check("zr r0 rbusy", 32'(rbusy_z[0]), 32'h0);
        check("nf r0 rdata next", rdata_n[0], 32'hFFFFFFFF);
        check("nf r0 busy_o", busy_n, 32'h1);
        check("nf r0 rbusy", 32'(rbusy_n[0]), 32'h1);

        // Out-of-range address on the 24-word instance.
        we = 2'b10; waddr[1] = 5'd30; wdata[1] = 32'h12345678;
        raddr[0] = 5'd30; rsv_valid = 1'b1; rsv_addr = 5'd30;
        raddr[1] = 5'd23;
        #3;
        check("zr oor rdata", rdata_z[0], 32'h0);
        check("zr oor rbusy", 32'(rbusy_z[0]), 32'h0);
        check("zr oor rsv_ready", 32'(ready_z), 32'h0);
        check("a r30 fwd rdata", rdata_a[0], 32'h12345678);
        @(posedge clk); #1;
        idle();
        raddr[0] = 5'd30;
        #3;
        check("zr oor busy_o", 32'(busy_z), 32'h0);
        check("zr oor rdata next", rdata_z[0], 32'h0);
        check("a r30 rdata next", rdata_a[0], 32'h12345678);

        // Forward=0: same-cycle read sees old value, next cycle sees the write.
        we = 2'b01; waddr[0] = 5'd9; wdata[0] = 32'hA5A5A5A5;
        raddr[0] = 5'd9; raddr[2] = 5'd9;
        #3;
        check("nf r9 same-cycle", rdata_n[0], 32'h0);
        check("a r9 fwd", rdata_a[2], 32'hA5A5A5A5);
        @(posedge clk); #1;
        idle();
        raddr[0] = 5'd9; raddr[2] = 5'd9;
        #3;
        check("nf r9 next p0", rdata_n[0], 32'hA5A5A5A5);
        check("nf r9 next p2", rdata_n[2], 32'hA5A5A5A5);
        check("zr r9 next", rdata_z[2], 32'hA5A5A5A5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
